// File: rtl/lycan_globals_pkg.sv
// Shared types and default constants for the Lycan USB datapath.
package lycan_globals;

    localparam int USB_PACKET_WIDTH   = 32;
    localparam int MAX_BURST_DEFAULT  = 256;
    localparam int RST_CYCLES_DEFAULT = 16;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        RD_OE,
        RD_BURST,
        RD_END,
        WR_BURST,
        WR_END
    } ft601_state_t;

    typedef enum logic {
        READ,
        WRITE
    } dir_t;

endpackage

// File: rtl/ft601_sync_fifo_if.sv
// FT601 245-synchronous-FIFO strobe controller with fair, bounded-burst
// arbitration between host reads (inbound FIFO) and device writes (FWFT outbound FIFO).
//
// state    | meaning
// RST_HOLD | FT601 held in reset, then wait for peripherals
// IDLE     | strobes high, buses released, arbitrate
// RD_OE    | FT601 output enable asserted one cycle before RD
// RD_BURST | OE+RD low, one word pushed per cycle with data
// RD_END   | turnaround before the bus can change owner
// WR_BURST | FPGA drives data/BE, WR low while FIFO head valid
// WR_END   | release buses before anything else
module ft601_sync_fifo_if
    import lycan_globals::*;
#(
    parameter int DATA_WIDTH = USB_PACKET_WIDTH,
    parameter int MAX_BURST  = MAX_BURST_DEFAULT,
    parameter int RST_CYCLES = RST_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    usb_tx_full,
    input  logic                    usb_rx_empty,
    output logic                    usb_wren_l,
    output logic                    usb_rden_l,
    output logic                    usb_outen_l,
    output logic                    usb_rst_l,
    output logic                    usb_data_tri,
    input  logic [DATA_WIDTH/8-1:0] be_in,
    output logic [DATA_WIDTH/8-1:0] be_out,
    output logic                    be_tri,
    output logic                    rx_push,
    output logic [DATA_WIDTH/8-1:0] rx_be,
    input  logic                    rx_almost_full,
    input  logic                    tx_avail,
    output logic                    tx_pop,
    input  logic                    periph_ready
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    ft601_state_t     state, state_nxt;
    dir_t             last_dir, last_dir_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [RST_W-1:0] rst_cnt;

    logic rd_req, wr_req;
    logic burst_at_max, burst_at_last;
    logic rd_done, wr_done;

    assign rd_req = ~usb_rx_empty & ~rx_almost_full;
    assign wr_req = ~usb_tx_full & tx_avail;

    // Burst limit counts the word transferred in the current cycle, so the
    // limit-th word is the last one of the burst.
    assign burst_at_max  = (burst_cnt == BURST_MAX);
    assign burst_at_last = (burst_cnt == BURST_LAST);
    assign rd_done = burst_at_max | (~usb_rx_empty & burst_at_last);
    assign wr_done = burst_at_max | (tx_avail & ~usb_tx_full & burst_at_last);

    assign usb_rst_l = ~((state == RST_HOLD) && (rst_cnt != '0));
    assign be_out    = '1;
    assign rx_be     = rx_push ? be_in : '0;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= RST_HOLD;
            last_dir  <= WRITE;
            burst_cnt <= '0;
            rst_cnt   <= RST_W'(RST_CYCLES);
        end else begin
            state     <= state_nxt;
            last_dir  <= last_dir_nxt;
            burst_cnt <= burst_cnt_nxt;
            if ((state == RST_HOLD) && (rst_cnt != '0))
                rst_cnt <= rst_cnt - RST_W'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        last_dir_nxt  = last_dir;
        burst_cnt_nxt = burst_cnt;
        usb_wren_l    = 1'b1;
        usb_rden_l    = 1'b1;
        usb_outen_l   = 1'b1;
        usb_data_tri  = 1'b1;
        be_tri        = 1'b1;
        rx_push       = 1'b0;
        tx_pop        = 1'b0;

        case (state)
            RST_HOLD: begin
                if ((rst_cnt == '0) && periph_ready)
                    state_nxt = IDLE;
            end
            IDLE: begin
                burst_cnt_nxt = '0;
                if (rd_req && wr_req)
                    state_nxt = (last_dir == WRITE) ? RD_OE : WR_BURST;
                else if (rd_req)
                    state_nxt = RD_OE;
                else if (wr_req)
                    state_nxt = WR_BURST;
            end
            RD_OE: begin
                usb_outen_l   = 1'b0;
                burst_cnt_nxt = '0;
                state_nxt     = RD_BURST;
            end
            RD_BURST: begin
                usb_outen_l = 1'b0;
                usb_rden_l  = 1'b0;
                rx_push     = ~usb_rx_empty;
                if (rx_push && !burst_at_max)
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                if (usb_rx_empty || rx_almost_full || (rd_done && wr_req))
                    state_nxt = RD_END;
            end
            RD_END: begin
                last_dir_nxt = READ;
                state_nxt    = IDLE;
            end
            WR_BURST: begin
                usb_data_tri = 1'b0;
                be_tri       = 1'b0;
                // WR only strobes on a valid FWFT head; a word leaves the FIFO
                // only when the FT601 actually samples it.
                usb_wren_l   = ~tx_avail;
                tx_pop       = tx_avail & ~usb_tx_full;
                if (tx_pop && !burst_at_max)
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                if (!tx_avail || usb_tx_full || (wr_done && rd_req))
                    state_nxt = WR_END;
            end
            WR_END: begin
                last_dir_nxt = WRITE;
                state_nxt    = IDLE;
            end
            default: state_nxt = RST_HOLD;
        endcase
    end

endmodule

// File: tb/tb_ft601_sync_fifo_if.sv
// Directed bench for ft601_sync_fifo_if: vector table plus multi-cycle sequences.
module tb_ft601_sync_fifo_if;

    logic       clk;
    logic       rst_l;
    logic       usb_tx_full;
    logic       usb_rx_empty;
    logic       usb_wren_l;
    logic       usb_rden_l;
    logic       usb_outen_l;
    logic       usb_rst_l;
    logic       usb_data_tri;
    logic [3:0] be_in;
    logic [3:0] be_out;
    logic       be_tri;
    logic       rx_push;
    logic [3:0] rx_be;
    logic       rx_almost_full;
    logic       tx_avail;
    logic       tx_pop;
    logic       periph_ready;

    ft601_sync_fifo_if #(
        .DATA_WIDTH(32),
        .MAX_BURST (4),
        .RST_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .usb_tx_full   (usb_tx_full),
        .usb_rx_empty  (usb_rx_empty),
        .usb_wren_l    (usb_wren_l),
        .usb_rden_l    (usb_rden_l),
        .usb_outen_l   (usb_outen_l),
        .usb_rst_l     (usb_rst_l),
        .usb_data_tri  (usb_data_tri),
        .be_in         (be_in),
        .be_out        (be_out),
        .be_tri        (be_tri),
        .rx_push       (rx_push),
        .rx_be         (rx_be),
        .rx_almost_full(rx_almost_full),
        .tx_avail      (tx_avail),
        .tx_pop        (tx_pop),
        .periph_ready  (periph_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rx_empty;
        logic       tx_full;
        logic       af;
        logic       avail;
        logic [3:0] be;
        logic       wren;
        logic       rden;
        logic       outen;
        logic       dtri;
        logic       push;
        logic       pop;
        logic [3:0] rxbe;
    } vec_t;

    vec_t  vecs[15];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    pushes, pops, host_words, txw, full_cnt, full_done;
    int    outen_fall, rden_fall, tri_bad, bad_pop, bad_drive;
    int    phase, af_cycles, af_push, resumed, got;
    logic  rden_at_end;
    logic [2:0] exp3;
    string pat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic re, input logic tf, input logic af, input logic av,
                                input logic [3:0] be, input logic wr, input logic rd,
                                input logic oe, input logic dt, input logic pu,
                                input logic po, input logic [3:0] rb);
        vec_t v;
        v.rx_empty = re; v.tx_full = tf; v.af = af; v.avail = av; v.be = be;
        v.wren = wr; v.rden = rd; v.outen = oe; v.dtri = dt;
        v.push = pu; v.pop = po; v.rxbe = rb;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //          re tf af av be     wr rd oe dt pu po rxbe
        vecs[0]  = mk(1, 0, 0, 0, 4'h5, 1, 1, 1, 1, 0, 0, 4'h0); // IDLE, nothing
        vecs[1]  = mk(0, 0, 1, 0, 4'h5, 1, 1, 1, 1, 0, 0, 4'h0); // data but FIFO almost full
        vecs[2]  = mk(0, 0, 0, 0, 4'h5, 1, 1, 1, 1, 0, 0, 4'h0); // read request
        vecs[3]  = mk(0, 0, 0, 0, 4'h5, 1, 1, 0, 1, 0, 0, 4'h0); // RD_OE
        vecs[4]  = mk(0, 0, 0, 0, 4'hA, 1, 0, 0, 1, 1, 0, 4'hA); // RD_BURST push
        vecs[5]  = mk(0, 0, 0, 0, 4'h3, 1, 0, 0, 1, 1, 0, 4'h3);
        vecs[6]  = mk(1, 0, 0, 0, 4'hC, 1, 0, 0, 1, 0, 0, 4'h0); // host runs dry
        vecs[7]  = mk(1, 0, 0, 0, 4'h5, 1, 1, 1, 1, 0, 0, 4'h0); // RD_END
        vecs[8]  = mk(1, 0, 0, 1, 4'h5, 1, 1, 1, 1, 0, 0, 4'h0); // IDLE, write request
        vecs[9]  = mk(1, 0, 0, 1, 4'h5, 0, 1, 1, 0, 0, 1, 4'h0); // WR_BURST pop
        vecs[10] = mk(1, 1, 0, 1, 4'h5, 0, 1, 1, 0, 0, 0, 4'h0); // TXE full: no pop
        vecs[11] = mk(1, 0, 0, 1, 4'h5, 1, 1, 1, 1, 0, 0, 4'h0); // WR_END
        vecs[12] = mk(1, 0, 0, 1, 4'h5, 1, 1, 1, 1, 0, 0, 4'h0); // IDLE, write again
        vecs[13] = mk(1, 0, 0, 0, 4'h5, 1, 1, 1, 0, 0, 0, 4'h0); // head gone: no strobe
        vecs[14] = mk(1, 0, 0, 0, 4'h5, 1, 1, 1, 1, 0, 0, 4'h0); // WR_END

        // Both directions pending from the start; reset hold ignores them.
        rst_l = 1'b0; usb_tx_full = 1'b0; usb_rx_empty = 1'b0; be_in = 4'h0;
        rx_almost_full = 1'b0; tx_avail = 1'b1; periph_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {usb_rst_l, usb_outen_l, usb_rden_l, usb_wren_l, usb_data_tri, be_tri, rx_push, tx_pop, be_out},
              {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF});
        @(negedge clk);
        rst_l = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("usb_rst_l_edge%0d", k), usb_rst_l, (k == 16) ? 1 : 0);
        end
        @(posedge clk);

        // Alternating bursts, MAX_BURST=4, starting with READ.
        pat = "--RRRR--WWWW---RRRR--WWWW";
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            if (i == 0)
                check("idle_strobes", {usb_rst_l, usb_outen_l, usb_rden_l, usb_wren_l}, 4'hF);
            case (pat[i])
                "R":     exp3 = 3'b101;
                "W":     exp3 = 3'b010;
                default: exp3 = 3'b001;
            endcase
            check($sformatf("alt[%0d]", i), {rx_push, tx_pop, usb_data_tri}, exp3);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            usb_rx_empty = 1'b1; tx_avail = 1'b0;
        end

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            usb_rx_empty = vecs[i].rx_empty; usb_tx_full = vecs[i].tx_full;
            rx_almost_full = vecs[i].af; tx_avail = vecs[i].avail; be_in = vecs[i].be;
            #1;
            check($sformatf("vec[%0d]", i),
                  {usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l, usb_data_tri, be_tri, rx_push, tx_pop, rx_be, be_out},
                  {vecs[i].wren, vecs[i].rden, vecs[i].outen, 1'b1, vecs[i].dtri, vecs[i].dtri,
                   vecs[i].push, vecs[i].pop, vecs[i].rxbe, 4'hF});
        end

        // Host sends 5 words.
        host_words = 5; pushes = 0; outen_fall = -1; rden_fall = -1; tri_bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            usb_rx_empty = (host_words == 0); usb_tx_full = 1'b0;
            rx_almost_full = 1'b0; tx_avail = 1'b0;
            #1;
            if (!usb_outen_l && outen_fall < 0) outen_fall = c;
            if (!usb_rden_l && rden_fall < 0) rden_fall = c;
            if (!usb_data_tri) tri_bad++;
            if (rx_push) begin pushes++; host_words--; end
        end
        check("rd5_pushes", pushes, 5);
        check("rd5_outen_lead", rden_fall - outen_fall, 1);
        check("rd5_bus_released", tri_bad, 0);
        check("rd5_back_idle", {usb_outen_l, usb_rden_l, usb_wren_l}, 3'b111);

        // Three outbound words, TXE full for 2 cycles on the second.
        txw = 3; pops = 0; full_cnt = 0; full_done = 0; bad_pop = 0; bad_drive = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            usb_rx_empty = 1'b1; rx_almost_full = 1'b0;
            if (pops == 1 && full_done == 0) begin full_cnt = 2; full_done = 1; end
            usb_tx_full = (full_cnt > 0);
            tx_avail = (txw > 0);
            #1;
            if (tx_pop && usb_tx_full) bad_pop++;
            if (!usb_data_tri && (!usb_outen_l || !usb_rden_l)) bad_drive++;
            if (tx_pop && usb_data_tri) bad_drive++;
            if (tx_pop) begin pops++; txw--; end
            if (full_cnt > 0) full_cnt--;
        end
        check("wr3_pops", pops, 3);
        check("wr3_no_pop_full", bad_pop, 0);
        check("wr3_bus_drive", bad_drive, 0);
        check("wr3_full_pulsed", full_done, 1);

        // Inbound FIFO nearly full mid-read.
        pushes = 0; phase = 0; af_cycles = 0; af_push = 0; resumed = 0; rden_at_end = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            usb_rx_empty = 1'b0; tx_avail = 1'b0; usb_tx_full = 1'b0;
            if (phase == 0 && pushes >= 2) phase = 1;
            if (phase == 1 && af_cycles == 6) phase = 2;
            rx_almost_full = (phase == 1);
            #1;
            if (phase == 1) begin
                if (rx_push) af_push++;
                af_cycles++;
                if (af_cycles == 6) rden_at_end = usb_rden_l;
            end
            if (phase == 2 && rx_push) resumed = 1;
            if (rx_push) pushes++;
        end
        check("af_extra_push", (af_push <= 1), 1);
        check("af_read_ended", rden_at_end, 1'b1);
        check("af_resumed", resumed, 1);

        // Reset asserted in the middle of a write burst.
        got = 0;
        for (int c = 0; c < 12 && got == 0; c++) begin
            @(negedge clk);
            usb_rx_empty = 1'b1; rx_almost_full = 1'b0; tx_avail = 1'b1; usb_tx_full = 1'b0;
            #1;
            if (!usb_wren_l) got = 1;
        end
        check("wr_burst_reached", got, 1);
        #2;
        rst_l = 1'b0;
        #1;
        check("rst_mid_wren", usb_wren_l, 1'b1);
        check("rst_mid_tri", {usb_data_tri, be_tri}, 2'b11);
        check("rst_mid_usb_rst", usb_rst_l, 1'b0);
        check("rst_mid_pop", tx_pop, 1'b0);
        check("rst_mid_rd", {usb_outen_l, usb_rden_l, rx_push}, 3'b110);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
